// File: rtl/cache_ctrl_4way_if.sv
// Bus bundle between the 4-way cache controller, the CPU, backing memory and the data array.
// The slave modport is the controller's view; master is the surrounding environment.
interface cache_ctrl_4way_if;
    logic         cpu_req;
    logic         cpu_we;
    logic [31:0]  cpu_addr;
    logic [31:0]  cpu_wdata;
    logic         cpu_done;
    logic [31:0]  cpu_rdata;
    logic         mem_req;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic [511:0] mem_wdata;
    logic [511:0] mem_rdata;
    logic         mem_ready;
    logic [6:0]   da_index;
    logic [1:0]   da_way;
    logic [3:0]   da_block_offset;
    logic [1:0]   da_word_offset;
    logic         da_we_block;
    logic         da_we_word;
    logic [511:0] da_block_in;
    logic [31:0]  da_word_in;
    logic [31:0]  da_word_out;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ready, da_word_out,
        output cpu_done, cpu_rdata, mem_req, mem_we, mem_addr, mem_wdata,
               da_index, da_way, da_block_offset, da_word_offset,
               da_we_block, da_we_word, da_block_in, da_word_in
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ready, da_word_out,
        input  cpu_done, cpu_rdata, mem_req, mem_we, mem_addr, mem_wdata,
               da_index, da_way, da_block_offset, da_word_offset,
               da_we_block, da_we_word, da_block_in, da_word_in
    );
endinterface

// File: rtl/cache_ctrl_4way.sv
// 4-way, 128-set, 64-byte-block write-back/write-allocate cache controller.
// Tags/valid/dirty/round-robin pointers live here; block data sits in an external array.
module cache_ctrl_4way (
    input  logic              clk,
    input  logic              rst_n,
    cache_ctrl_4way_if.slave  io_bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_EVICT,
        S_WB,
        S_REFILL
    } state_t;

    state_t        r_state;
    state_t        w_state_next;

    logic [31:0]   r_addr;
    logic          r_we;
    logic [31:0]   r_wdata;
    logic [1:0]    r_victim;
    logic [18:0]   r_victim_tag;
    logic          r_victim_from_ptr;
    logic [3:0]    r_cnt;
    logic [511:0]  r_wb_buf;
    logic          r_cpu_done;
    logic [31:0]   r_cpu_rdata;

    logic [18:0]   r_tag   [0:127][0:3];
    logic [3:0]    r_valid [0:127];
    logic [3:0]    r_dirty [0:127];
    logic [1:0]    r_ptr   [0:127];

    logic [6:0]    w_index;
    logic [18:0]   w_tag;
    logic [3:0]    w_hit_vec;
    logic          w_hit;
    logic [1:0]    w_hit_way;
    logic [1:0]    w_victim;
    logic          w_victim_from_ptr;
    logic          w_victim_dirty;
    logic          w_accept;
    logic          w_refill_done;

    logic          w_mem_req;
    logic          w_mem_we;
    logic [31:0]   w_mem_addr;
    logic [511:0]  w_mem_wdata;
    logic [1:0]    w_da_way;
    logic [3:0]    w_da_block_offset;
    logic          w_da_we_block;
    logic          w_da_we_word;
    logic [511:0]  w_da_block_in;
    logic [31:0]   w_da_word_in;

    assign w_index = r_addr[12:6];
    assign w_tag   = r_addr[31:13];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_hit
            assign w_hit_vec[gi] = r_valid[w_index][gi] && (r_tag[w_index][gi] == w_tag);
        end
    endgenerate

    assign w_hit = |w_hit_vec;

    always_comb begin
        w_hit_way = 2'd0;
        for (int w = 3; w >= 0; w--) begin
            if (w_hit_vec[w]) w_hit_way = 2'(w);
        end
    end

    // Lowest invalid way wins; only a full set falls back to the round-robin pointer.
    always_comb begin
        w_victim          = r_ptr[w_index];
        w_victim_from_ptr = 1'b1;
        for (int w = 3; w >= 0; w--) begin
            if (!r_valid[w_index][w]) begin
                w_victim          = 2'(w);
                w_victim_from_ptr = 1'b0;
            end
        end
    end

    assign w_victim_dirty = r_valid[w_index][w_victim] && r_dirty[w_index][w_victim];
    assign w_accept       = (r_state == S_IDLE) && io_bus.cpu_req && !r_cpu_done;
    assign w_refill_done  = (r_state == S_REFILL) && io_bus.mem_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next      = r_state;
        w_mem_req         = 1'b0;
        w_mem_we          = 1'b0;
        w_mem_addr        = 32'd0;
        w_mem_wdata       = 512'd0;
        w_da_way          = 2'd0;
        w_da_block_offset = r_addr[5:2];
        w_da_we_block     = 1'b0;
        w_da_we_word      = 1'b0;
        w_da_block_in     = 512'd0;
        w_da_word_in      = 32'd0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_next = S_LOOKUP;
            end
            S_LOOKUP: begin
                if (w_hit) begin
                    w_da_way     = w_hit_way;
                    w_da_we_word = r_we;
                    w_da_word_in = r_we ? r_wdata : 32'd0;
                    w_state_next = S_IDLE;
                end else begin
                    w_state_next = w_victim_dirty ? S_EVICT : S_REFILL;
                end
            end
            S_EVICT: begin
                w_da_way          = r_victim;
                w_da_block_offset = r_cnt;
                if (r_cnt == 4'd15) w_state_next = S_WB;
            end
            S_WB: begin
                w_mem_req   = 1'b1;
                w_mem_we    = 1'b1;
                w_mem_addr  = {r_victim_tag, w_index, 6'b0};
                w_mem_wdata = r_wb_buf;
                if (io_bus.mem_ready) w_state_next = S_REFILL;
            end
            S_REFILL: begin
                w_mem_req  = 1'b1;
                w_mem_addr = {w_tag, w_index, 6'b0};
                if (io_bus.mem_ready) begin
                    w_da_we_block = 1'b1;
                    w_da_way      = r_victim;
                    w_da_block_in = io_bus.mem_rdata;
                    w_state_next  = S_LOOKUP;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_addr            <= 32'd0;
            r_we              <= 1'b0;
            r_wdata           <= 32'd0;
            r_victim          <= 2'd0;
            r_victim_tag      <= 19'd0;
            r_victim_from_ptr <= 1'b0;
            r_cnt             <= 4'd0;
            r_wb_buf          <= 512'd0;
            r_cpu_done        <= 1'b0;
            r_cpu_rdata       <= 32'd0;
            for (int s = 0; s < 128; s++) begin
                r_valid[s] <= 4'd0;
                r_dirty[s] <= 4'd0;
                r_ptr[s]   <= 2'd0;
            end
        end else begin
            r_cpu_done  <= 1'b0;
            r_cpu_rdata <= 32'd0;
            if (w_accept) begin
                r_addr  <= io_bus.cpu_addr;
                r_we    <= io_bus.cpu_we;
                r_wdata <= io_bus.cpu_wdata;
            end
            if (r_state == S_LOOKUP) begin
                if (w_hit) begin
                    r_cpu_done  <= 1'b1;
                    r_cpu_rdata <= io_bus.da_word_out;
                    if (r_we) r_dirty[w_index][w_hit_way] <= 1'b1;
                end else begin
                    r_victim          <= w_victim;
                    r_victim_tag      <= r_tag[w_index][w_victim];
                    r_victim_from_ptr <= w_victim_from_ptr;
                    r_cnt             <= 4'd0;
                end
            end
            if (r_state == S_EVICT) begin
                r_wb_buf[{r_cnt, 5'b0} +: 32] <= io_bus.da_word_out;
                r_cnt                         <= r_cnt + 4'd1;
            end
            if (w_refill_done) begin
                r_valid[w_index][r_victim] <= 1'b1;
                r_dirty[w_index][r_victim] <= 1'b0;
                if (r_victim_from_ptr) r_ptr[w_index] <= r_ptr[w_index] + 2'd1;
            end
        end
    end

    // Tags need no reset: a line is only trusted once its valid bit is set.
    always_ff @(posedge clk) begin
        if (w_refill_done) r_tag[w_index][r_victim] <= w_tag;
    end

    assign io_bus.cpu_done        = r_cpu_done;
    assign io_bus.cpu_rdata       = r_cpu_rdata;
    assign io_bus.mem_req         = w_mem_req;
    assign io_bus.mem_we          = w_mem_we;
    assign io_bus.mem_addr        = w_mem_addr;
    assign io_bus.mem_wdata       = w_mem_wdata;
    assign io_bus.da_index        = w_index;
    assign io_bus.da_way          = w_da_way;
    assign io_bus.da_block_offset = w_da_block_offset;
    assign io_bus.da_word_offset  = r_addr[1:0];
    assign io_bus.da_we_block     = w_da_we_block;
    assign io_bus.da_we_word      = w_da_we_word;
    assign io_bus.da_block_in     = w_da_block_in;
    assign io_bus.da_word_in      = w_da_word_in;
endmodule

// File: tb/tb_cache_ctrl_4way.sv
// Directed testbench for cache_ctrl_4way: data-array and memory models plus scenario tasks
// with hand-computed expectations.
module tb_cache_ctrl_4way;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cache_ctrl_4way_if bus();

    cache_ctrl_4way dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus.slave)
    );

    logic [31:0] da_mem [0:127][0:3][0:15];
    assign bus.da_word_out = da_mem[bus.da_index][bus.da_way][bus.da_block_offset];

    always @(posedge clk) begin
        if (bus.da_we_block) begin
            for (int k = 0; k < 16; k++) da_mem[bus.da_index][bus.da_way][k] <= bus.da_block_in[32*k +: 32];
        end
        if (bus.da_we_word) da_mem[bus.da_index][bus.da_way][bus.da_block_offset] <= bus.da_word_in;
    end

    int total = 0;
    int bad   = 0;

    // Observations gathered by run_xact for the scenario tasks to judge.
    logic         o_done, o_timeout, o_both, o_unstable;
    int           o_cycles, o_first_req, o_n_fetch, o_n_wb, o_blk_cnt, o_word_cnt;
    logic [31:0]  o_rdata, o_fetch_addr, o_wb_addr;
    logic [511:0] o_wb_data;
    logic [1:0]   o_blk_way;
    logic [3:0]   o_word_off;
    logic [3:0]   off_log [0:31];
    logic [1:0]   way_log [0:31];

    function automatic logic [511:0] blk(input logic [31:0] a);
        logic [511:0] b;
        b = '0;
        for (int k = 0; k < 16; k++)
            b[32*k +: 32] = (a == 32'h0000_2040) ? (32'hA5A5_0000 + 32'(k)) : ({a[15:0], 16'h0} + 32'(k));
        return b;
    endfunction

    task automatic run_xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        logic         holding;
        int           hold_cnt;
        logic         h_we;
        logic [31:0]  h_addr;
        logic [511:0] h_wdata;
        o_done = 0; o_timeout = 0; o_both = 0; o_unstable = 0;
        o_cycles = 0; o_first_req = -1; o_n_fetch = 0; o_n_wb = 0; o_blk_cnt = 0; o_word_cnt = 0;
        o_rdata = '0; o_fetch_addr = '0; o_wb_addr = '0; o_wb_data = '0; o_blk_way = '0; o_word_off = '0;
        for (int i = 0; i < 32; i++) begin off_log[i] = '0; way_log[i] = '0; end
        holding = 0; hold_cnt = 0; h_we = 0; h_addr = '0; h_wdata = '0;
        @(negedge clk);
        bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata; bus.mem_ready = 1'b0;
        for (int c = 1; c <= 150 && !o_done; c++) begin
            @(negedge clk);
            bus.mem_ready = 1'b0;
            #1;
            if (c < 32) begin off_log[c] = bus.da_block_offset; way_log[c] = bus.da_way; end
            if (bus.da_we_word) begin o_word_cnt++; o_word_off = bus.da_block_offset; end
            if (bus.cpu_done) begin
                o_done = 1; o_cycles = c; o_rdata = bus.cpu_rdata;
                bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
            end else if (bus.mem_req) begin
                if (!holding) begin
                    holding = 1; hold_cnt = 0;
                    h_we = bus.mem_we; h_addr = bus.mem_addr; h_wdata = bus.mem_wdata;
                    if (o_first_req < 0) o_first_req = c;
                    if (h_we) begin o_n_wb++; o_wb_addr = h_addr; o_wb_data = h_wdata; end
                    else begin o_n_fetch++; o_fetch_addr = h_addr; end
                end else if (bus.mem_we !== h_we || bus.mem_addr !== h_addr || bus.mem_wdata !== h_wdata) begin
                    o_unstable = 1;
                end
                hold_cnt++;
                if (hold_cnt == 3) begin
                    bus.mem_ready = 1'b1;
                    bus.mem_rdata = h_we ? '0 : blk(h_addr);
                    holding = 0;
                    #1;
                    if (bus.da_we_block) begin o_blk_cnt++; o_blk_way = bus.da_way; end
                    if (bus.da_we_block && bus.da_we_word) o_both = 1;
                end
            end else begin
                holding = 0;
            end
        end
        if (!o_done) begin
            o_timeout = 1;
            bus.cpu_req = 1'b0;
        end
        $display("xact %s addr=0x%08h wdata=0x%08h -> done=%0b cycles=%0d rdata=0x%08h fetch=%0d wb=%0d",
                 we ? "WR" : "RD", addr, wdata, o_done, o_cycles, o_rdata, o_n_fetch, o_n_wb);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk); @(negedge clk); #1;
        total++; if (bus.cpu_done !== 1'b0) begin bad++; $display("FAIL rst_cpu_done got=%b want=0", bus.cpu_done); end
        total++; if (bus.cpu_rdata !== 32'd0) begin bad++; $display("FAIL rst_cpu_rdata got=%h want=0", bus.cpu_rdata); end
        total++; if (bus.mem_req !== 1'b0 || bus.mem_we !== 1'b0) begin bad++; $display("FAIL rst_mem_req got=%b/%b want=0/0", bus.mem_req, bus.mem_we); end
        total++; if (bus.mem_addr !== 32'd0 || bus.mem_wdata !== 512'd0) begin bad++; $display("FAIL rst_mem_bus got addr=%h want=0", bus.mem_addr); end
        total++; if (bus.da_we_block !== 1'b0 || bus.da_we_word !== 1'b0) begin bad++; $display("FAIL rst_da_we got=%b/%b want=0/0", bus.da_we_block, bus.da_we_word); end
        total++; if ({bus.da_index, bus.da_way, bus.da_block_offset, bus.da_word_offset} !== 15'd0) begin
            bad++; $display("FAIL rst_da_addr got=%h/%h/%h/%h want=0", bus.da_index, bus.da_way, bus.da_block_offset, bus.da_word_offset); end
        rst_n = 1'b1;
    endtask

    task automatic test_read_miss();
        run_xact(1'b0, 32'h0000_2044, 32'd0);
        total++; if (o_timeout !== 1'b0) begin bad++; $display("FAIL rdmiss_timeout got=%b want=0", o_timeout); end
        total++; if (o_first_req !== 2) begin bad++; $display("FAIL rdmiss_req_cycle got=%0d want=2", o_first_req); end
        total++; if (o_n_fetch !== 1 || o_n_wb !== 0) begin bad++; $display("FAIL rdmiss_mem_ops got=fetch%0d/wb%0d want=1/0", o_n_fetch, o_n_wb); end
        total++; if (o_fetch_addr !== 32'h0000_2040) begin bad++; $display("FAIL rdmiss_fetch_addr got=%h want=00002040", o_fetch_addr); end
        total++; if (o_blk_cnt !== 1 || o_blk_way !== 2'd0) begin bad++; $display("FAIL rdmiss_blk_write got=cnt%0d/way%0d want=1/0", o_blk_cnt, o_blk_way); end
        total++; if (o_rdata !== 32'hA5A5_0001) begin bad++; $display("FAIL rdmiss_rdata got=%h want=a5a50001", o_rdata); end
        total++; if (o_cycles !== 6) begin bad++; $display("FAIL rdmiss_latency got=%0d want=6", o_cycles); end
        total++; if (o_unstable !== 1'b0 || o_both !== 1'b0) begin bad++; $display("FAIL rdmiss_bus_rules got=unstable%b/both%b want=0/0", o_unstable, o_both); end
    endtask

    task automatic test_read_hit();
        run_xact(1'b0, 32'h0000_2044, 32'd0);
        total++; if (o_cycles !== 2) begin bad++; $display("FAIL rdhit_latency got=%0d want=2", o_cycles); end
        total++; if (o_rdata !== 32'hA5A5_0001) begin bad++; $display("FAIL rdhit_rdata got=%h want=a5a50001", o_rdata); end
        total++; if (o_first_req !== -1) begin bad++; $display("FAIL rdhit_mem_req got=%0d want=-1", o_first_req); end
    endtask

    task automatic test_write_hit();
        run_xact(1'b1, 32'h0000_2048, 32'hDEAD_BEEF);
        total++; if (o_cycles !== 2) begin bad++; $display("FAIL wrhit_latency got=%0d want=2", o_cycles); end
        total++; if (o_word_cnt !== 1 || o_word_off !== 4'd2) begin bad++; $display("FAIL wrhit_word_we got=cnt%0d/off%0d want=1/2", o_word_cnt, o_word_off); end
        total++; if (o_first_req !== -1) begin bad++; $display("FAIL wrhit_mem_req got=%0d want=-1", o_first_req); end
        run_xact(1'b0, 32'h0000_2048, 32'd0);
        total++; if (o_rdata !== 32'hDEAD_BEEF || o_cycles !== 2) begin bad++; $display("FAIL wrhit_readback got=%h/%0d want=deadbeef/2", o_rdata, o_cycles); end
    endtask

    task automatic test_fill_set();
        logic [31:0] addrs [0:2];
        addrs[0] = 32'h0000_4040; addrs[1] = 32'h0000_6040; addrs[2] = 32'h0000_8040;
        for (int i = 0; i < 3; i++) begin
            run_xact(1'b0, addrs[i], 32'd0);
            total++; if (o_blk_way !== 2'(i + 1) || o_n_wb !== 0) begin bad++; $display("FAIL fill_way%0d got=way%0d/wb%0d want=%0d/0", i + 1, o_blk_way, o_n_wb, i + 1); end
            total++; if (o_rdata !== {addrs[i][15:0], 16'h0}) begin bad++; $display("FAIL fill_rdata%0d got=%h want=%h", i + 1, o_rdata, {addrs[i][15:0], 16'h0}); end
        end
    endtask

    task automatic test_evict();
        run_xact(1'b0, 32'h0000_C040, 32'd0);
        total++; if (o_first_req !== 18) begin bad++; $display("FAIL evict_wb_cycle got=%0d want=18", o_first_req); end
        for (int k = 0; k < 16; k++) begin
            total++; if (off_log[k + 2] !== 4'(k) || way_log[k + 2] !== 2'd0) begin
                bad++; $display("FAIL evict_step%0d got=off%0d/way%0d want=%0d/0", k, off_log[k + 2], way_log[k + 2], k); end
        end
        total++; if (o_n_wb !== 1 || o_wb_addr !== 32'h0000_2040) begin bad++; $display("FAIL evict_wb_addr got=%0d/%h want=1/00002040", o_n_wb, o_wb_addr); end
        total++; if (o_wb_data[64 +: 32] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL evict_wb_word2 got=%h want=deadbeef", o_wb_data[64 +: 32]); end
        total++; if (o_wb_data[32 +: 32] !== 32'hA5A5_0001 || o_wb_data[480 +: 32] !== 32'hA5A5_000F) begin
            bad++; $display("FAIL evict_wb_words got=%h/%h want=a5a50001/a5a5000f", o_wb_data[32 +: 32], o_wb_data[480 +: 32]); end
        total++; if (o_n_fetch !== 1 || o_fetch_addr !== 32'h0000_C040) begin bad++; $display("FAIL evict_refill got=%0d/%h want=1/0000c040", o_n_fetch, o_fetch_addr); end
        total++; if (o_blk_way !== 2'd0 || o_rdata !== 32'hC040_0000) begin bad++; $display("FAIL evict_result got=way%0d/%h want=0/c0400000", o_blk_way, o_rdata); end
        total++; if (o_cycles !== 25 || o_unstable !== 1'b0) begin bad++; $display("FAIL evict_timing got=%0d/unstable%b want=25/0", o_cycles, o_unstable); end
        // Pointer advanced to 1, so the next full-set miss replaces way 1 (clean).
        run_xact(1'b0, 32'h0000_E040, 32'd0);
        total++; if (o_blk_way !== 2'd1 || o_n_wb !== 0 || o_first_req !== 2) begin
            bad++; $display("FAIL ptr_victim got=way%0d/wb%0d/req%0d want=1/0/2", o_blk_way, o_n_wb, o_first_req); end
    endtask

    task automatic test_write_miss();
        run_xact(1'b1, 32'h0000_2050, 32'h1234_5678);
        total++; if (o_blk_way !== 2'd2 || o_n_fetch !== 1 || o_fetch_addr !== 32'h0000_2040) begin
            bad++; $display("FAIL wrmiss_refill got=way%0d/%0d/%h want=2/1/00002040", o_blk_way, o_n_fetch, o_fetch_addr); end
        total++; if (o_word_cnt !== 1 || o_word_off !== 4'd4) begin bad++; $display("FAIL wrmiss_word_we got=cnt%0d/off%0d want=1/4", o_word_cnt, o_word_off); end
        run_xact(1'b0, 32'h0000_2050, 32'd0);
        total++; if (o_rdata !== 32'h1234_5678 || o_cycles !== 2) begin bad++; $display("FAIL wrmiss_readback got=%h/%0d want=12345678/2", o_rdata, o_cycles); end
        run_xact(1'b0, 32'h0000_2044, 32'd0);
        total++; if (o_rdata !== 32'hA5A5_0001 || o_cycles !== 2) begin bad++; $display("FAIL wrmiss_neighbor got=%h/%0d want=a5a50001/2", o_rdata, o_cycles); end
    endtask

    task automatic test_round_robin();
        logic [31:0] addrs [0:2];
        logic [1:0]  ways  [0:2];
        addrs[0] = 32'h0001_0040; addrs[1] = 32'h0001_2040; addrs[2] = 32'h0001_4040;
        ways[0]  = 2'd3;          ways[1]  = 2'd0;          ways[2]  = 2'd1;
        for (int i = 0; i < 3; i++) begin
            run_xact(1'b0, addrs[i], 32'd0);
            total++; if (o_blk_way !== ways[i] || o_n_wb !== 0) begin bad++; $display("FAIL rr_step%0d got=way%0d/wb%0d want=%0d/0", i, o_blk_way, o_n_wb, ways[i]); end
        end
    endtask

    task automatic test_reset_in_wb();
        logic found;
        found = 1'b0;
        @(negedge clk);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h0001_6040; bus.mem_ready = 1'b0;
        for (int c = 1; c <= 60 && !found; c++) begin
            @(negedge clk); #1;
            if (bus.mem_req && bus.mem_we) found = 1'b1;
        end
        total++; if (found !== 1'b1) begin bad++; $display("FAIL rstwb_reach_wb got=%b want=1", found); end
        total++; if (bus.mem_addr !== 32'h0000_2040) begin bad++; $display("FAIL rstwb_wb_addr got=%h want=00002040", bus.mem_addr); end
        rst_n = 1'b0; bus.cpu_req = 1'b0;
        @(negedge clk); #1;
        total++; if (bus.mem_req !== 1'b0 || bus.mem_we !== 1'b0 || bus.mem_addr !== 32'd0) begin
            bad++; $display("FAIL rstwb_mem_drop got=%b/%b/%h want=0/0/0", bus.mem_req, bus.mem_we, bus.mem_addr); end
        total++; if (bus.cpu_done !== 1'b0 || bus.da_we_block !== 1'b0) begin bad++; $display("FAIL rstwb_outputs got=%b/%b want=0/0", bus.cpu_done, bus.da_we_block); end
        rst_n = 1'b1;
        $display("xact RD addr=0x00016040 interrupted by reset during writeback");
        run_xact(1'b0, 32'h0000_2044, 32'd0);
        total++; if (o_n_fetch !== 1 || o_fetch_addr !== 32'h0000_2040 || o_first_req !== 2) begin
            bad++; $display("FAIL rstwb_remiss got=%0d/%h/req%0d want=1/00002040/2", o_n_fetch, o_fetch_addr, o_first_req); end
        total++; if (o_rdata !== 32'hA5A5_0001 || o_blk_way !== 2'd0) begin bad++; $display("FAIL rstwb_rdata got=%h/way%0d want=a5a50001/0", o_rdata, o_blk_way); end
    endtask

    initial begin
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.mem_ready = 1'b0; bus.mem_rdata = '0;
        test_reset();
        test_read_miss();
        test_read_hit();
        test_write_hit();
        test_fill_set();
        test_evict();
        test_write_miss();
        test_round_robin();
        test_reset_in_wb();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
